// File: rtl/arbiter_rr4.sv
// Four-requester round-robin arbiter with a registered one-hot grant and an idle cycle between grants.
// Optional grant-hold timeout with a re-eligibility mask is compiled in by defining ARBITER_TIMEOUT_EN.
module arbiter_rr4 #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_reg;
  logic [1:0] ptr_reg;
  logic [1:0] idx_reg;
  logic [3:0] gnt_reg;
  logic       valid_reg;
  logic       timeout_reg;

  logic [3:0] elig;
  logic [3:0] rot;
  logic       pick_found;
  logic [1:0] pick_off;
  logic [1:0] pick_idx;

  generate
    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
      $error("arbiter_rr4: HOLD_MAX must lie in 2..255");
    end
  endgenerate

`ifdef ARBITER_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] hold_cnt_reg;
  logic [3:0] inelig_reg;

  // A requester that timed out stays masked until it is seen with req low.
  assign elig = req & ~inelig_reg;
`else
  assign elig = req;
`endif

  // rot[k] is the eligibility of requester ptr+k, so the lowest set bit wins.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign rot[gi] = elig[ptr_reg + 2'(gi)];
    end
  endgenerate

  always_comb begin
    pick_found = |rot;
    pick_off   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (rot[k]) pick_off = 2'(k);
    end
    pick_idx = ptr_reg + pick_off;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ptr_reg      <= 2'd0;
      idx_reg      <= 2'd0;
      gnt_reg      <= 4'd0;
      valid_reg    <= 1'b0;
      timeout_reg  <= 1'b0;
`ifdef ARBITER_TIMEOUT_EN
      hold_cnt_reg <= 8'd0;
      inelig_reg   <= 4'd0;
`endif
    end else begin
      timeout_reg <= 1'b0;
`ifdef ARBITER_TIMEOUT_EN
      for (int i = 0; i < 4; i++) begin
        if (!req[i]) inelig_reg[i] <= 1'b0;
      end
`endif
      unique case (state_reg)
        IDLE: begin
          if (ena && pick_found) begin
            state_reg    <= GRANT;
            gnt_reg      <= 4'b0001 << pick_idx;
            idx_reg      <= pick_idx;
            valid_reg    <= 1'b1;
`ifdef ARBITER_TIMEOUT_EN
            hold_cnt_reg <= 8'd0;
`endif
          end
        end
        GRANT: begin
          // Release is checked first so it wins over a coincident timeout.
          if (!req[idx_reg]) begin
            state_reg    <= IDLE;
            gnt_reg      <= 4'd0;
            idx_reg      <= 2'd0;
            valid_reg    <= 1'b0;
            ptr_reg      <= idx_reg + 2'd1;
`ifdef ARBITER_TIMEOUT_EN
            hold_cnt_reg <= 8'd0;
          end else if (hold_cnt_reg == HOLD_LAST) begin
            state_reg           <= IDLE;
            gnt_reg             <= 4'd0;
            idx_reg             <= 2'd0;
            valid_reg           <= 1'b0;
            ptr_reg             <= idx_reg + 2'd1;
            timeout_reg         <= 1'b1;
            inelig_reg[idx_reg] <= 1'b1;
            hold_cnt_reg        <= 8'd0;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 8'd1;
`endif
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_idx   = idx_reg;
  assign gnt_valid = valid_reg;
  assign timeout   = timeout_reg;

endmodule

// File: doc/arbiter_rr4.md
ARBITER_RR4 -- requirements
Module: arbiter_rr4

Interface
REQ-001 Parameter HOLD_MAX, default 16, maximum consecutive cycles one grant may be held (timeout feature only); legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ena  input  1  arbiter enable; gates issue of new grants only.
REQ-005 req  input  4  per-requester request; requester i holds req[i] high for the whole use of the shared resource.
REQ-006 gnt  output  4  one-hot grant, registered; all-zero when no grant.
REQ-007 gnt_idx  output  2  binary index of the granted requester; 0 when gnt_valid is 0.
REQ-008 gnt_valid  output  1  high exactly when gnt is non-zero.
REQ-009 timeout  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-010 The block SHALL implement a two-state FSM, IDLE and GRANT.
REQ-011 IDLE: if ena=1 and any eligible req bit is set at a rising edge, the block SHALL select the first eligible requester scanning ptr, ptr+1, ... mod 4, and SHALL enter GRANT with gnt/gnt_idx/gnt_valid registered at that edge (1-cycle latency from sampled req).
REQ-012 IDLE with ena=0 or no eligible request SHALL remain IDLE with gnt=0.
REQ-013 GRANT: while req[gnt_idx]=1 (and no timeout), gnt SHALL hold unchanged regardless of ena or other req bits.
REQ-014 GRANT: at the edge sampling req[gnt_idx]=0, the block SHALL clear gnt, set ptr to gnt_idx+1 mod 4 (3 wraps to 0), and return to IDLE.
REQ-015 At least one IDLE cycle (gnt=0) SHALL separate any two grants, including back-to-back grants to different requesters.
REQ-016 gnt SHALL never have more than one bit set; gnt SHALL equal the 1-to-4 decode of gnt_idx gated by gnt_valid.
REQ-017 Requests arriving or dropping on non-granted lines during GRANT SHALL have no effect until the next IDLE arbitration.
REQ-018 ptr SHALL change only on grant termination; a requester denied in IDLE loses no priority.

Reset
REQ-019 rst_n=0 SHALL immediately (asynchronously) force state=IDLE, ptr=0, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, hold counter=0, eligibility mask cleared.
REQ-020 Reset asserted during GRANT SHALL drop the grant without pulsing timeout; after rst_n rises, first arbitration uses ptr=0.

Configuration
REQ-021 Macro ARBITER_TIMEOUT_EN, when defined, SHALL compile in an 8-bit hold counter that counts GRANT cycles, cleared on entry to GRANT.
REQ-022 With ARBITER_TIMEOUT_EN: when gnt has been high HOLD_MAX cycles and req[gnt_idx] is still 1, the next edge SHALL clear gnt, pulse timeout for one cycle, advance ptr as in REQ-014, and mark that requester ineligible.
REQ-023 With ARBITER_TIMEOUT_EN: an ineligible requester SHALL become eligible again on the first edge it is sampled with req=0; if the owner releases on the same edge timeout would fire, release wins and timeout SHALL stay 0.
REQ-024 Without ARBITER_TIMEOUT_EN: no counter or mask SHALL exist, grants SHALL be held indefinitely, all requesters are always eligible, and timeout SHALL be tied 0; HOLD_MAX is ignored.

Verification
REQ-025 Reset, ena=1, req=4'b0101 held -> gnt=4'b0001 one cycle after sample; drop req[0] -> gnt=0 next cycle, then gnt=4'b0100, gnt_idx=2.
REQ-026 All req=4'b1111 with each owner releasing after 3 cycles -> grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-027 Owner 3 releases -> ptr wraps; req=4'b1001 next -> gnt=4'b0001.
REQ-028 ena=0, req=4'b0010 -> gnt stays 0; ena=1 -> gnt=4'b0010 next cycle; ena=0 during GRANT -> grant held.
REQ-029 rst_n pulsed low mid-GRANT (gnt=4'b0100) -> gnt=0 immediately, timeout=0; after release, req=4'b1111 -> gnt=4'b0001.
REQ-030 ARBITER_TIMEOUT_EN, HOLD_MAX=4, req=4'b0011 held -> gnt=4'b0001 for 4 cycles, timeout pulse, gnt=4'b0010 after idle cycle; requester 0 not re-granted until req[0] drops and reasserts.
